switch_allocator: RTL and testbench

- Per-output-port wormhole switch allocator for the flattened-butterfly router.
- Sits directly upstream of the router crossbar and drives its one-hot select array: output o, input i maps to bit o*INPORT+i.
- Arbitrates input head flits per output with round-robin fairness.
- Locks each output to the winning input until that packet's tail flit transfers.

---
 rtl/switch_allocator_pkg.sv | 13 +
 rtl/switch_allocator_if.sv | 27 ++
 rtl/switch_allocator_rr_arbiter.sv | 27 ++
 rtl/switch_allocator.sv | 133 +++++++++++++
 tb/tb_switch_allocator.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/switch_allocator_pkg.sv
// Shared router definitions for the flattened-butterfly switch allocator.
package fb_router_pkg;

    localparam int INPORT_DEF  = 5;
    localparam int OUTPORT_DEF = 5;
    localparam int STAT_W      = 16;

    typedef enum logic {
        ALLOC_IDLE,
        ALLOC_LOCKED
    } alloc_state_e;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input units and the switch allocator.
interface switch_allocator_if
    import fb_router_pkg::*;
#(
    parameter int INPORT  = INPORT_DEF,
    parameter int OUTPORT = OUTPORT_DEF
);

    logic [0:INPORT-1]         req_valid;
    logic [0:INPORT-1]         req_head;
    logic [0:INPORT-1]         req_tail;
    logic [0:INPORT*OUTPORT-1] req_dest;
    logic [0:OUTPORT-1]        out_ready;
    logic [0:INPORT-1]         gnt;
    logic [0:OUTPORT*INPORT-1] select_array;

    modport master (
        output req_valid, req_head, req_tail, req_dest, out_ready,
        input  gnt, select_array
    );

    modport slave (
        input  req_valid, req_head, req_tail, req_dest, out_ready,
        output gnt, select_array
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int  N     = 5,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [0:N-1]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [0:N-1]     gnt
);

    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator with round-robin head arbitration.
// Define SW_ALLOC_STATS_EN to add per-output transfer counters.
module switch_allocator
    import fb_router_pkg::*;
#(
    parameter int  INPORT  = INPORT_DEF,
    parameter int  OUTPORT = OUTPORT_DEF,
    localparam int PTR_W   = $clog2(INPORT)
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SW_ALLOC_STATS_EN
    output logic [0:OUTPORT*STAT_W-1] stat_flit_cnt,
`endif
    switch_allocator_if.slave bus
);

    logic [0:INPORT-1]         dest_ok;
    logic [0:INPORT-1]         gnt_w;
    logic [0:OUTPORT*INPORT-1] select_w;

    // A request is only eligible when its destination is exactly one-hot
    always_comb begin
        dest_ok = '0;
        for (int i = 0; i < INPORT; i++) begin
            dest_ok[i] = bus.req_valid[i]
                       & $onehot(bus.req_dest[i*OUTPORT +: OUTPORT]);
        end
    end

    for (genvar o = 0; o < OUTPORT; o++) begin : g_out
        logic [0:INPORT-1] qual;
        logic [0:INPORT-1] cand;
        logic [0:INPORT-1] arb_gnt;
        logic [0:INPORT-1] sel;
        logic [PTR_W-1:0]  win;
        logic [PTR_W-1:0]  ptr_q, ptr_d;
        logic [PTR_W-1:0]  owner_q, owner_d;
        alloc_state_e      state_q, state_d;

        always_comb begin
            qual = '0;
            for (int i = 0; i < INPORT; i++) begin
                qual[i] = dest_ok[i] & bus.req_dest[i*OUTPORT+o];
            end
        end

        assign cand = qual & bus.req_head;

        rr_arbiter #(.N(INPORT)) u_arb (
            .req (cand),
            .ptr (ptr_q),
            .gnt (arb_gnt)
        );

        always_comb begin
            win = '0;
            for (int i = 0; i < INPORT; i++) begin
                if (arb_gnt[i]) win = PTR_W'(i);
            end
        end

        always_comb begin
            state_d = state_q;
            ptr_d   = ptr_q;
            owner_d = owner_q;
            sel     = '0;
            unique case (state_q)
                ALLOC_IDLE: begin
                    if (bus.out_ready[o] && |cand) begin
                        sel   = arb_gnt;
                        ptr_d = (win == PTR_W'(INPORT-1)) ?
                                '0 : win + PTR_W'(1);
                        if (!bus.req_tail[win]) begin
                            state_d = ALLOC_LOCKED;
                            owner_d = win;
                        end
                    end
                end
                ALLOC_LOCKED: begin
                    if (bus.out_ready[o] && qual[owner_q]) begin
                        sel[owner_q] = 1'b1;
                        if (bus.req_tail[owner_q]) state_d = ALLOC_IDLE;
                    end
                end
                default: state_d = ALLOC_IDLE;
            endcase
            if (!rst_n) sel = '0;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ALLOC_IDLE;
                ptr_q   <= '0;
                owner_q <= '0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                owner_q <= owner_d;
            end
        end

        assign select_w[o*INPORT +: INPORT] = sel;

`ifdef SW_ALLOC_STATS_EN
        logic [STAT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q + STAT_W'(|sel);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign stat_flit_cnt[o*STAT_W +: STAT_W] = cnt_q;
`endif
    end

    always_comb begin
        gnt_w = '0;
        for (int o = 0; o < OUTPORT; o++) begin
            for (int i = 0; i < INPORT; i++) begin
                gnt_w[i] = gnt_w[i] | select_w[o*INPORT+i];
            end
        end
    end

    assign bus.gnt          = gnt_w;
    assign bus.select_array = select_w;

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: expected selects queued per cycle.
module tb_switch_allocator;
    import fb_router_pkg::*;

    localparam int NI = 5;
    localparam int NO = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [0:NO*NI-1] exp_q [$];

    switch_allocator_if #(.INPORT(NI), .OUTPORT(NO)) bus ();

`ifdef SW_ALLOC_STATS_EN
    logic [0:NO*STAT_W-1] stat;
`endif

    switch_allocator #(.INPORT(NI), .OUTPORT(NO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef SW_ALLOC_STATS_EN
        .stat_flit_cnt (stat),
`endif
        .bus           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [0:NO*NI-1] sb(input int o, input int i);
        logic [0:NO*NI-1] v;
        v = '0;
        v[o*NI+i] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:NI-1] gnt_of(input logic [0:NO*NI-1] s);
        logic [0:NI-1] g;
        g = '0;
        for (int o = 0; o < NO; o++)
            for (int i = 0; i < NI; i++)
                if (s[o*NI+i]) g[i] = 1'b1;
        return g;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [0:NO*NI-1] e;
            e = exp_q.pop_front();
            chk("sel", 32'(bus.select_array), 32'(e));
            chk("gnt", 32'(bus.gnt), 32'(gnt_of(e)));
        end
    end

    task automatic clr();
        bus.req_valid = '0;
        bus.req_head  = '0;
        bus.req_tail  = '0;
        bus.req_dest  = '0;
        bus.out_ready = '1;
    endtask

    task automatic put(input int i, input int o,
                       input logic h, input logic t);
        bus.req_valid[i] = 1'b1;
        bus.req_head[i]  = h;
        bus.req_tail[i]  = t;
        for (int k = 0; k < NO; k++) bus.req_dest[i*NO+k] = (k == o);
    endtask

    task automatic step(input logic [0:NO*NI-1] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clr();
        put(0, 2, 1'b1, 1'b1);
        #3;
        chk("rst_sel", 32'(bus.select_array), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clr();

        // single-flit packets, then ptr wrap from 4
        put(0, 2, 1, 1); put(3, 2, 1, 1); step(sb(2, 0));
        put(3, 2, 1, 1);                  step(sb(2, 3));
        put(0, 2, 1, 1); put(4, 2, 1, 1); step(sb(2, 4));
        put(0, 2, 1, 1);                  step(sb(2, 0));

        // wormhole lock with backpressure mid-packet
        put(1, 0, 1, 0); put(4, 0, 1, 1); step(sb(0, 1));
        put(1, 0, 0, 0); put(4, 0, 1, 1); step(sb(0, 1));
        put(1, 0, 0, 1); put(4, 0, 1, 1);
        bus.out_ready[0] = 1'b0;          step('0);
        put(1, 0, 0, 1); put(4, 0, 1, 1);
        bus.out_ready[0] = 1'b0;          step('0);
        put(1, 0, 0, 1); put(4, 0, 1, 1); step(sb(0, 1));
        put(4, 0, 1, 1);                  step(sb(0, 4));
        put(2, 0, 0, 0);                  step('0);

        // parallel outputs
        put(0, 1, 1, 1); put(2, 3, 1, 1); put(4, 0, 1, 1);
        step(sb(1, 0) | sb(3, 2) | sb(0, 4));

        // malformed destinations
        put(2, 1, 1, 1); bus.req_dest[2*NO+2] = 1'b1; step('0);
        put(2, 1, 1, 1); bus.req_dest[2*NO+2] = 1'b1;
        put(0, 3, 1, 1); bus.req_dest[0*NO+3] = 1'b0; step('0);
        put(3, 1, 1, 1);                  step(sb(1, 3));

        // reset while output 0 is locked to input 1
        put(1, 0, 1, 0);                  step(sb(0, 1));
        put(1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(bus.select_array), 32'd0);
        chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef SW_ALLOC_STATS_EN
        chk("stat_rst", 32'(stat[0 +: STAT_W]), 32'd0);
`endif
        clr();
        put(1, 0, 0, 0); put(3, 0, 1, 1); step(sb(0, 3));
`ifdef SW_ALLOC_STATS_EN
        chk("stat_cnt", 32'(stat[0 +: STAT_W]), 32'd1);
`endif

        for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
